hs_arbiter: RTL and testbench
=============================

Name: hs_arbiter

Overview:
- Round-robin arbiter that shares one four-phase req/ack reader between NREQ four-phase writers.
- Each writer follows the same protocol:
  - raise req and wait for ack;
  - present data on q for the cycle after ack is seen;
  - drop req and wait for ack low.
- The arbiter grants one writer at a time and forwards that writer's req/q to the reader and the reader's ack back to it.
- Non-granted writers see ack=0 until they are granted.

Parameters:
- NREQ, 4, number of writer channels (2..16)
- W, 8, data width of each q bus

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  NREQ  per-writer request; bit i belongs to writer i
- wr_ack  out  NREQ  per-writer acknowledge
- wr_q  in  NREQ*W  writer data; writer i occupies bits [i*W +: W]
- rd_req  out  1  request to the shared reader
- rd_ack  in  1  acknowledge from the shared reader
- rd_q  out  W  data to the shared reader
- gnt  out  NREQ  one-hot registered grant; all zero when idle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, gnt=0, ptr=NREQ-1, so channel 0 has first priority.
  - All outputs are 0 while reset_n=0, including the combinational rd_req, rd_q and wr_ack.
- States: IDLE, GRANT, HOLD.
- IDLE:
  - If any wr_req bit is high at the clock edge, choose the first set bit searching upward from (ptr+1) mod NREQ, wrapping.
  - Register the choice as gnt=onehot(g) and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Combinational forwarding: rd_req=wr_req[g], wr_ack[g]=rd_ack, rd_q=wr_q[g].
  - rd_ack=1 at an edge -> HOLD.
  - wr_req[g]=0 and rd_ack=0 at an edge (writer abandoned before ack) -> IDLE, ptr<=g.
- HOLD:
  - Same forwarding as GRANT.
  - Wait until wr_req[g]=0 and rd_ack=0 at the same edge, then -> IDLE, ptr<=g, gnt<=0.
- Forwarding is purely combinational from the registered g, so the writer's "data valid the cycle after ack" timing reaches the reader unchanged.
- In IDLE: rd_req=0, rd_q=0, wr_ack=0.
- In any state, wr_ack[j] for j != g is 0.
- Latency:
  - wr_req[i] high at edge n (from IDLE) -> gnt and rd_req high after edge n.
  - After HOLD exits there is one mandatory IDLE cycle before the next grant.
- Fairness: a channel that has just been served has the lowest priority for the next arbitration. With all NREQ requesting, service order is ptr+1, ptr+2, ... wrapping.
- Simultaneous events:
  - Requests arriving while not in IDLE wait; they are never lost because writers hold req until acked.
  - A request from the granted channel arriving in the same cycle HOLD exits is arbitrated normally in the next IDLE cycle.
- Reset mid-transfer: everything drops immediately; the reader and writers must tolerate the aborted handshake.
- Widths: g is a clog2(NREQ)-bit index; the pointer increment wraps modulo NREQ, including non-power-of-two NREQ.

Optional Feature:
- Macro HS_ARBITER_STATS_EN.
- When defined:
  - Adds output xfer_cnt [15:0], reset to 0.
  - Increments by 1 on each GRANT->HOLD transition, i.e. each completed data transfer, wrapping 16'hFFFF -> 0.
  - Adds output abort_cnt [7:0] counting GRANT->IDLE aborts, saturating at 8'hFF.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with wr_req=4'b1111 -> gnt=0, rd_req=0, wr_ack=0, rd_q=0. Release -> gnt=4'b0001 one cycle later.
- Single writer: writer 2 only, q=8'hA5; reader acks after 3 cycles.
  - rd_req follows wr_req[2]; wr_ack[2] follows rd_ack.
  - rd_q=8'hA5 in the data cycle.
  - Other wr_ack bits stay 0; busy drops after req and ack are both low.
- Round robin: wr_req=4'b1111 held continuously with a reader that always acks.
  - Grant order is 0,1,2,3,0,1.
  - Exactly one IDLE cycle between grants.
- Fairness after skip: ptr=1, then wr_req=4'b1001 -> grant 3 first, then 0.
- Abort: channel 1 granted, wr_req[1] drops before rd_ack -> IDLE next cycle, next grant skips past 1. With HS_ARBITER_STATS_EN: abort_cnt=1, xfer_cnt unchanged.
- Mid-transfer reset: assert reset_n=0 in HOLD -> rd_req and wr_ack fall in the same cycle, and the next grant after release is channel 0.
  - With HS_ARBITER_STATS_EN: 65537 transfers -> xfer_cnt=1.

Source files
------------

// File: rtl/hs_arbiter.sv
// ============================================================================
// Module      : hs_arbiter
// Description : Round-robin arbiter sharing one four-phase req/ack reader
//               between NREQ four-phase writers. The granted writer's req/q
//               are forwarded combinationally to the reader and the reader's
//               ack is returned to that writer only.
//               Optional statistics counters: define HS_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   wr_req,
    output logic [NREQ-1:0]   wr_ack,
    input  logic [NREQ*W-1:0] wr_q,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [W-1:0]      rd_q,
    output logic [NREQ-1:0]   gnt,
    output logic              busy
`ifdef HS_ARBITER_STATS_EN
    ,
    output logic [15:0]       xfer_cnt,
    output logic [7:0]        abort_cnt
`endif
);

    localparam int c_gw = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_sw = c_gw + 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_grant = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;

    logic [1:0]      r_state;
    logic [c_gw-1:0] r_g;
    logic [c_gw-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt;

    logic [c_gw-1:0] w_pick;
    logic            w_found;
    logic [c_sw-1:0] w_sum;
    logic            w_active;
    logic            w_req_g;
    logic [W-1:0]    w_rd_q;
    logic            w_to_hold;
    logic            w_abort;

    // Rotating search: first requester strictly after the last-served channel.
    // The sum is one bit wider than the index so the modulo wrap is exact for
    // non-power-of-two NREQ.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_sw'(k);
            if (w_sum >= c_sw'(NREQ)) begin
                w_sum = w_sum - c_sw'(NREQ);
            end
            if (!w_found && wr_req[w_sum[c_gw-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_gw-1:0];
            end
        end
    end

    // Forwarding is gated by reset as well so outputs are zero the moment
    // reset asserts, independent of register update ordering.
    assign w_active  = reset_n && (r_state != c_idle);
    assign w_req_g   = |(wr_req & r_gnt);
    assign w_to_hold = (r_state == c_grant) && rd_ack;
    assign w_abort   = (r_state == c_grant) && !rd_ack && !w_req_g;

    // Data mux driven by the one-hot grant register.
    always_comb begin
        w_rd_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_rd_q = wr_q[i*W +: W];
            end
        end
    end

    assign rd_req = w_active && w_req_g;
    assign wr_ack = w_active ? (r_gnt & {NREQ{rd_ack}}) : '0;
    assign rd_q   = w_active ? w_rd_q : '0;
    assign gnt    = r_gnt;
    assign busy   = (r_state != c_idle);

    // Arbitration state machine; the served channel becomes the new pointer
    // so it has the lowest priority in the next arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_g     <= '0;
            r_ptr   <= c_gw'(NREQ - 1);
            r_gnt   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_found) begin
                        r_g     <= w_pick;
                        r_gnt   <= NREQ'(1) << w_pick;
                        r_state <= c_grant;
                    end
                end
                c_grant: begin
                    if (rd_ack) begin
                        r_state <= c_hold;
                    end else if (!w_req_g) begin
                        r_ptr   <= r_g;
                        r_gnt   <= '0;
                        r_state <= c_idle;
                    end
                end
                c_hold: begin
                    if (!w_req_g && !rd_ack) begin
                        r_ptr   <= r_g;
                        r_gnt   <= '0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef HS_ARBITER_STATS_EN
    logic [15:0] r_xfer_cnt;
    logic [7:0]  r_abort_cnt;

    // Completed transfers wrap; aborts saturate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xfer_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_to_hold) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if (w_abort && (r_abort_cnt != 8'hFF)) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end
        end
    end

    assign xfer_cnt  = r_xfer_cnt;
    assign abort_cnt = r_abort_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hs_arbiter.sv
// ============================================================================
// Module      : tb_hs_arbiter
// Description : Self-checking bench for hs_arbiter. A transaction-level model
//               (owner index, last-served index) predicts every output each
//               cycle; writer/reader agents generate legal four-phase traffic
//               and a raw random phase exercises aborts and resets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   wr_req;
    logic [NREQ-1:0]   wr_ack;
    logic [NREQ*W-1:0] wr_q;
    logic              rd_req;
    logic              rd_ack;
    logic [W-1:0]      rd_q;
    logic [NREQ-1:0]   gnt;
    logic              busy;
`ifdef HS_ARBITER_STATS_EN
    logic [15:0]       xfer_cnt;
    logic [7:0]        abort_cnt;
`endif

    hs_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_q     (wr_q),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_q     (rd_q),
        .gnt      (gnt),
        .busy     (busy)
`ifdef HS_ARBITER_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the reader, whether the reader has acked,
    // and which channel was served last.
    int m_owner;
    int m_ptr;
    bit m_acked;
    int m_xfer;
    int m_abort;

    // Agents and observation
    bit          auto_wr, auto_rd, fix_a5;
    bit [3:0]    want;
    int          wphase [NREQ];
    int          rdelay, rcnt;
    logic        s_rdreq;
    logic [3:0]  s_wrack;
    logic [3:0]  prev_gnt;
    int          idle_run;
    int          order[$];
    int          gaps[$];
    logic [7:0]  seen_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = NREQ - 1;
        m_acked = 0;
        m_xfer  = 0;
        m_abort = 0;
    endtask

    function automatic int rr_search(int p, logic [3:0] req);
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (m_owner < 0) begin
            m_owner = rr_search(m_ptr, wr_req);
            m_acked = 0;
        end else if (!m_acked) begin
            if (rd_ack) begin
                m_acked = 1;
                m_xfer  = (m_xfer + 1) % 65536;
            end else if (!wr_req[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
                if (m_abort < 255) m_abort++;
            end
        end else if (!wr_req[m_owner] && !rd_ack) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, ea;
        logic       er;
        logic [7:0] eq;
        eg = 4'b0; ea = 4'b0; er = 1'b0; eq = 8'h0;
        if (m_owner >= 0) begin
            eg = 4'(1 << m_owner);
            er = wr_req[m_owner];
            ea = rd_ack ? eg : 4'b0;
            eq = wr_q[m_owner*W +: W];
        end
        chk("gnt",    32'(gnt),    32'(eg));
        chk("busy",   32'(busy),   32'(m_owner >= 0));
        chk("rd_req", 32'(rd_req), 32'(er));
        chk("wr_ack", 32'(wr_ack), 32'(ea));
        chk("rd_q",   32'(rd_q),   32'(eq));
`ifdef HS_ARBITER_STATS_EN
        chk("xfer_cnt",  32'(xfer_cnt),  32'(m_xfer));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
`endif
        s_rdreq = rd_req;
        s_wrack = wr_ack;
        if (gnt != 4'b0 && prev_gnt == 4'b0) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
            gaps.push_back(idle_run);
            idle_run = 0;
        end
        if (!busy) idle_run++;
        prev_gnt = gnt;
        if (auto_wr && wphase[2] == 2) seen_data = rd_q;
    endtask

    task automatic agents_update();
        if (auto_wr) begin
            for (int i = 0; i < NREQ; i++) begin
                case (wphase[i])
                    0: if (want[i]) wphase[i] = 1;
                    1: if (s_wrack[i]) wphase[i] = 2;
                    2: wphase[i] = 3;
                    default: if (!s_wrack[i]) wphase[i] = want[i] ? 1 : 0;
                endcase
                wr_req[i] = (wphase[i] == 1) || (wphase[i] == 2);
            end
        end
        if (auto_rd) begin
            rcnt   = s_rdreq ? rcnt + 1 : 0;
            rd_ack = s_rdreq && (rcnt >= rdelay);
        end
    endtask

    // One clock: check settled outputs, advance model at the edge, then
    // drive the next inputs one time unit after the edge.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        agents_update();
        wr_q = {$urandom};
        if (fix_a5) wr_q[2*W +: W] = 8'hA5;
    endtask

    task automatic set_all_phase(int p);
        for (int i = 0; i < NREQ; i++) wphase[i] = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        auto_wr = 0; auto_rd = 0; fix_a5 = 0; want = 4'h0;
        rdelay = 1; rcnt = 0; prev_gnt = 4'h0; idle_run = 0; seen_data = 8'h00;
        set_all_phase(0);
        reset_n = 1'b0; wr_req = 4'hF; rd_ack = 1'b0; wr_q = {$urandom};
        model_reset();

        // Reset held with all requests: everything stays zero.
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("rst_first_gnt", 32'(gnt), 32'h1);

        // Round robin: all writers request continuously, reader always acks.
        want = 4'hF; set_all_phase(1); rcnt = 0; rdelay = 1;
        auto_wr = 1; auto_rd = 1;
        for (int n = 0; n < 40; n++) cycle();
        want = 4'h0;
        for (int n = 0; n < 40; n++) cycle();
        begin
            int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
            chk("rr_count_ok", 32'(order.size() >= 6), 32'h1);
            for (int k = 0; k < 6 && k < order.size(); k++)
                chk("rr_order", 32'(order[k]), 32'(rr_exp[k]));
            for (int k = 1; k < 6 && k < gaps.size(); k++)
                chk("rr_idle_gap", 32'(gaps[k]), 32'h1);
        end

        // Single writer 2 with data A5 and a slow reader.
        fix_a5 = 1; rdelay = 3; want = 4'b0100; seen_data = 8'h00;
        for (int n = 0; n < 20; n++) cycle();
        want = 4'h0;
        for (int n = 0; n < 8; n++) cycle();
        chk("single_data", 32'(seen_data), 32'hA5);
        chk("single_idle", 32'(busy), 32'h0);
        fix_a5 = 0; rdelay = 1;

        // Fairness after skip: serve channel 1, then 3 and 0 request together.
        want = 4'b0010;
        for (int n = 0; n < 12; n++) cycle();
        want = 4'b1001;
        order.delete(); gaps.delete();
        for (int n = 0; n < 30; n++) cycle();
        want = 4'h0;
        for (int n = 0; n < 10; n++) cycle();
        chk("fair_first",  32'(order.size() > 0 ? order[0] : -1), 32'd3);
        chk("fair_second", 32'(order.size() > 1 ? order[1] : -1), 32'd0);

        // Abort: channel 1 granted then dropped before ack.
        auto_wr = 0; auto_rd = 0; set_all_phase(0);
        wr_req = 4'b0010; rd_ack = 1'b0;
        cycle();
        cycle();
        wr_req = 4'b0000;
        cycle();
        chk("abort_idle", 32'(busy), 32'h0);
        wr_req = 4'b1110;
        cycle();
        chk("abort_skip", 32'(gnt), 32'b0100);
        wr_req = 4'b0000;
        cycle();
        cycle();

        // Mid-transfer reset from HOLD.
        want = 4'hF; auto_wr = 1; auto_rd = 1; rcnt = 0;
        for (int n = 0; n < 30 && !(m_owner >= 0 && m_acked); n++) cycle();
        chk("hold_reached", 32'(m_owner >= 0 && m_acked && busy), 32'h1);
        auto_wr = 0; auto_rd = 0;
        reset_n = 1'b0; model_reset();
        #1;
        chk("midrst_rd_req", 32'(rd_req), 32'h0);
        chk("midrst_wr_ack", 32'(wr_ack), 32'h0);
        wr_req = 4'hF; rd_ack = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("midrst_next_gnt", 32'(gnt), 32'h1);

        // Random legal traffic from the agents.
        set_all_phase(1); rcnt = 0; auto_wr = 1; auto_rd = 1;
        for (int n = 0; n < 300; n++) begin
            want   = 4'($urandom);
            rdelay = $urandom_range(1, 3);
            cycle();
        end

        // Raw random inputs, including aborts and occasional resets.
        auto_wr = 0; auto_rd = 0;
        for (int n = 0; n < 400; n++) begin
            wr_req = 4'($urandom);
            rd_ack = 1'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else begin
                reset_n = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
